// File: rtl/sequence_pkg.sv
// Shared definitions for the VeriRISC sequence controller: opcode encodings,
// the phase/state encoding and the opcode classification helper.
package sequence_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // P0..P7 share their encoding with the phase number so phase can be sliced off
    typedef enum logic [3:0] {
        P0     = 4'd0,
        P1     = 4'd1,
        P2     = 4'd2,
        P3     = 4'd3,
        P4     = 4'd4,
        P5     = 4'd5,
        P6     = 4'd6,
        P7     = 4'd7,
        WAIT   = 4'd8,
        HALTED = 4'd9
    } state_e;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/sequence_controller.sv
// VeriRISC instruction sequencer: steps each instruction through eight phases,
// with single-step parking, a sticky halt and a retired-instruction counter.
module sequence_controller
    import sequence_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             halt,
    output logic             ld_pc,
    output logic             data_e,
    output logic             ld_ac,
    output logic             wr,
    output logic [2:0]       phase,
    output logic             waiting,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic             aluOp, skzTaken, isHlt, isSto, isJmp;

    assign aluOp    = is_aluop(opcode);
    assign isHlt    = (opcode == HLT);
    assign isSto    = (opcode == STO);
    assign isJmp    = (opcode == JMP);
    assign skzTaken = (opcode == SKZ) && zero;

    // Next-state selection; retire marks the edge on which an instruction completes
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            P0:      state_d = step_mode ? WAIT : P1;
            P1:      state_d = P2;
            P2:      state_d = P3;
            P3:      state_d = P4;
            P4: begin
                if (isHlt) begin
                    state_d = HALTED;
                    retire  = 1'b1;
                end else begin
                    state_d = P5;
                end
            end
            P5:      state_d = P6;
            P6:      state_d = P7;
            P7: begin
                state_d = step_mode ? WAIT : P0;
                retire  = 1'b1;
            end
            // Fetch address is already on the bus while parked, so resume at P1
            WAIT:    state_d = (step_req || !step_mode) ? P1 : WAIT;
            HALTED:  state_d = HALTED;
            default: state_d = P0;
        endcase
    end

    assign count_d = retire ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= P0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Strobes decode from the registered phase plus the live opcode/zero inputs
    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        halt    = 1'b0;
        ld_pc   = 1'b0;
        data_e  = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        waiting = 1'b0;
        phase   = 3'(state_q);
        case (state_q)
            P0:      sel = 1'b1;
            P1: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            P2, P3: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            P4: begin
                inc_pc = 1'b1;
                halt   = isHlt;
            end
            P5:      rd = aluOp;
            P6: begin
                rd     = aluOp;
                inc_pc = skzTaken;
                ld_pc  = isJmp;
                data_e = isSto;
            end
            P7: begin
                rd     = aluOp;
                ld_ac  = aluOp;
                ld_pc  = isJmp;
                wr     = isSto;
                data_e = isSto;
            end
            WAIT: begin
                sel     = 1'b1;
                waiting = 1'b1;
                phase   = 3'd0;
            end
            HALTED: begin
                halt  = 1'b1;
                phase = 3'd4;
            end
            default: phase = 3'd0;
        endcase
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: directed scenarios plus random
// stimulus, all checked against an instruction-level reference model.
module tb_sequence_controller;

    logic        clk;
    logic        rst;
    logic [2:0]  opcode;
    logic        zero;
    logic        step_mode;
    logic        step_req;

    logic        sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, waiting;
    logic [2:0]  phase;
    logic [15:0] count16;

    logic        wSel, wRd, wLdIr, wIncPc, wHalt, wLdPc, wDataE, wLdAc, wWr, wWaiting;
    logic [2:0]  wPhase;
    logic [1:0]  countW;

    logic [12:0] dutVec, wVec;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: position within the instruction (0-7) plus parked/halted flags
    int          mPos   = 0;
    bit          mWait  = 0;
    bit          mHalt  = 0;
    int unsigned mCount = 0;

    sequence_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .step_mode(step_mode), .step_req(step_req),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
        .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
        .phase(phase), .waiting(waiting), .instr_count(count16)
    );

    sequence_controller #(.CNT_W(2)) dutW (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .step_mode(step_mode), .step_req(step_req),
        .sel(wSel), .rd(wRd), .ld_ir(wLdIr), .inc_pc(wIncPc), .halt(wHalt),
        .ld_pc(wLdPc), .data_e(wDataE), .ld_ac(wLdAc), .wr(wWr),
        .phase(wPhase), .waiting(wWaiting), .instr_count(countW)
    );

    assign dutVec = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, waiting, phase};
    assign wVec   = {wSel, wRd, wLdIr, wIncPc, wHalt, wLdPc, wDataE, wLdAc, wWr, wWaiting, wPhase};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the instruction rules, written as phase ranges
    function automatic logic [12:0] expVec();
        bit alu, eSel, eRd, eIr, eInc, eHalt, eLdPc, eDataE, eLdAc, eWr, eWait;
        logic [2:0] ePhase;
        alu    = (opcode >= 3'd2) && (opcode <= 3'd5);
        eSel   = 0; eRd = 0; eIr = 0; eInc = 0; eHalt = 0;
        eLdPc  = 0; eDataE = 0; eLdAc = 0; eWr = 0; eWait = 0;
        ePhase = 3'(mPos);
        if (mHalt) begin
            eHalt  = 1;
            ePhase = 3'd4;
        end else if (mWait) begin
            eSel   = 1;
            eWait  = 1;
            ePhase = 3'd0;
        end else begin
            eSel   = (mPos < 4);
            eRd    = (mPos >= 1 && mPos <= 3) || (mPos >= 5 && alu);
            eIr    = (mPos == 2 || mPos == 3);
            eInc   = (mPos == 4) || (mPos == 6 && opcode == 3'd1 && zero);
            eHalt  = (mPos == 4 && opcode == 3'd0);
            eLdPc  = (mPos >= 6 && opcode == 3'd7);
            eDataE = (mPos >= 6 && opcode == 3'd6);
            eLdAc  = (mPos == 7 && alu);
            eWr    = (mPos == 7 && opcode == 3'd6);
        end
        return {eSel, eRd, eIr, eInc, eHalt, eLdPc, eDataE, eLdAc, eWr, eWait, ePhase};
    endfunction

    function automatic void modelEdge();
        if (rst) begin
            mPos = 0; mWait = 0; mHalt = 0; mCount = 0;
        end else if (mHalt) begin
            mHalt = 1;
        end else if (mWait) begin
            if (step_req || !step_mode) begin
                mWait = 0;
                mPos  = 1;
            end
        end else if (mPos == 4 && opcode == 3'd0) begin
            mHalt = 1;
            mCount++;
        end else if (mPos == 7) begin
            mCount++;
            mPos  = 0;
            mWait = step_mode;
        end else if (mPos == 0 && step_mode) begin
            mWait = 1;
        end else begin
            mPos++;
        end
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        step_req = 1'b0;
        applyStimulus();
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        step_mode = 1'b0;
        step_req  = 1'b0;
        opcode    = 3'($urandom);
        zero      = 1'($urandom);
        applyStimulus();
        applyStimulus();
        #1;
        checkCount++;
        if (dutVec !== 13'b1_0000_0000_0_000)
            $display("[TB] FAIL reset_outputs: got %b expected %b", dutVec, 13'b1_0000_0000_0_000);
        else passCount++;
        checkCount++;
        if (count16 !== 16'd0 || countW !== 2'd0)
            $display("[TB] FAIL reset_count: got %0d/%0d expected 0/0", count16, countW);
        else passCount++;
        rst = 1'b0;
        checkCount++;
        if (dutVec !== expVec())
            $display("[TB] FAIL reset_model: got %b expected %b", dutVec, expVec());
        else passCount++;
    endtask

    task automatic test_lda();
        resetDut();
        step_mode = 1'b0;
        opcode    = 3'd5;
        for (int c = 0; c < 8; c++) begin
            zero = 1'($urandom);
            #1;
            checkCount++;
            if (dutVec !== expVec())
                $display("[TB] FAIL lda_cycle%0d: got %b expected %b", c, dutVec, expVec());
            else passCount++;
            applyStimulus();
        end
        #1;
        checkCount++;
        if (count16 !== 16'd1 || phase !== 3'd0)
            $display("[TB] FAIL lda_retire: got count %0d phase %0d expected count 1 phase 0", count16, phase);
        else passCount++;
    endtask

    task automatic test_sto_jmp();
        logic [2:0] ops [2];
        ops[0] = 3'd6;
        ops[1] = 3'd7;
        resetDut();
        step_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i];
            for (int c = 0; c < 8; c++) begin
                zero = 1'($urandom);
                #1;
                checkCount++;
                if (dutVec !== expVec())
                    $display("[TB] FAIL sto_jmp_op%0d_cycle%0d: got %b expected %b", ops[i], c, dutVec, expVec());
                else passCount++;
                applyStimulus();
            end
        end
        #1;
        checkCount++;
        if (count16 !== 16'd2)
            $display("[TB] FAIL sto_jmp_count: got %0d expected 2", count16);
        else passCount++;
    endtask

    task automatic test_skz();
        resetDut();
        step_mode = 1'b0;
        for (int z = 1; z >= 0; z--) begin
            for (int c = 0; c < 8; c++) begin
                // Early phases see junk on opcode/zero, which must not matter
                if (c < 4) begin
                    opcode = 3'($urandom);
                    zero   = 1'($urandom);
                end else begin
                    opcode = 3'd1;
                    zero   = 1'(z);
                end
                #1;
                checkCount++;
                if (dutVec !== expVec())
                    $display("[TB] FAIL skz_z%0d_cycle%0d: got %b expected %b", z, c, dutVec, expVec());
                else passCount++;
                applyStimulus();
            end
        end
    endtask

    task automatic test_hlt();
        resetDut();
        step_mode = 1'b0;
        opcode    = 3'd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkCount++;
            if (dutVec !== expVec())
                $display("[TB] FAIL hlt_cycle%0d: got %b expected %b", c, dutVec, expVec());
            else passCount++;
            applyStimulus();
        end
        for (int c = 0; c < 20; c++) begin
            step_req  = 1'($urandom);
            step_mode = 1'($urandom);
            opcode    = 3'($urandom);
            #1;
            checkCount++;
            if (dutVec !== 13'b0000_1000_0_0_100)
                $display("[TB] FAIL hlt_hold%0d: got %b expected %b", c, dutVec, 13'b0000_1000_0_0_100);
            else passCount++;
            applyStimulus();
        end
        step_req = 1'b0;
        #1;
        checkCount++;
        if (count16 !== 16'd1)
            $display("[TB] FAIL hlt_count: got %0d expected 1", count16);
        else passCount++;
        resetDut();
        #1;
        checkCount++;
        if (halt !== 1'b0 || phase !== 3'd0)
            $display("[TB] FAIL hlt_exit: got halt %b phase %0d expected halt 0 phase 0", halt, phase);
        else passCount++;
    endtask

    task automatic test_step_mode();
        step_mode = 1'b1;
        opcode    = 3'd2;
        resetDut();
        for (int c = 0; c < 11; c++) begin
            zero = 1'($urandom);
            #1;
            checkCount++;
            if (dutVec !== expVec() || (c > 0 && waiting !== 1'b1))
                $display("[TB] FAIL step_park%0d: got %b expected %b", c, dutVec, expVec());
            else passCount++;
            applyStimulus();
        end
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 8; c++) begin
                step_req = (c == 0 || c == 3);
                #1;
                checkCount++;
                if (dutVec !== expVec())
                    $display("[TB] FAIL step_run%0d_cycle%0d: got %b expected %b", n, c, dutVec, expVec());
                else passCount++;
                applyStimulus();
            end
            step_req = 1'b0;
            #1;
            checkCount++;
            if (waiting !== 1'b1 || count16 !== 16'(n + 1))
                $display("[TB] FAIL step_done%0d: got waiting %b count %0d expected waiting 1 count %0d",
                         n, waiting, count16, n + 1);
            else passCount++;
        end
        step_mode = 1'b0;
    endtask

    task automatic test_wrap();
        int wrapExp [5] = '{1, 2, 3, 0, 1};
        step_mode = 1'b0;
        resetDut();
        for (int i = 0; i < 5; i++) begin
            opcode = 3'($urandom_range(1, 7));
            for (int c = 0; c < 8; c++) begin
                zero = 1'($urandom);
                #1;
                checkCount++;
                if (wVec !== expVec())
                    $display("[TB] FAIL wrap_i%0d_cycle%0d: got %b expected %b", i, c, wVec, expVec());
                else passCount++;
                applyStimulus();
            end
            #1;
            checkCount++;
            if (countW !== 2'(wrapExp[i]))
                $display("[TB] FAIL wrap_count%0d: got %0d expected %0d", i, countW, wrapExp[i]);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid();
        step_mode = 1'b0;
        resetDut();
        opcode = 3'd7;
        for (int c = 0; c < 6; c++) applyStimulus();
        #1;
        checkCount++;
        if (ld_pc !== 1'b1 || phase !== 3'd6)
            $display("[TB] FAIL mid_p6: got ld_pc %b phase %0d expected ld_pc 1 phase 6", ld_pc, phase);
        else passCount++;
        resetDut();
        #1;
        checkCount++;
        if (ld_pc !== 1'b0 || phase !== 3'd0 || sel !== 1'b1)
            $display("[TB] FAIL mid_reset: got ld_pc %b phase %0d sel %b expected 0 0 1", ld_pc, phase, sel);
        else passCount++;
    endtask

    task automatic test_random();
        resetDut();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            opcode    = 3'($urandom);
            zero      = 1'($urandom);
            step_mode = ($urandom_range(0, 3) == 0);
            step_req  = 1'($urandom);
            #1;
            checkCount++;
            if (dutVec !== expVec() || wVec !== expVec())
                $display("[TB] FAIL random%0d_outputs: got %b/%b expected %b", c, dutVec, wVec, expVec());
            else passCount++;
            checkCount++;
            if (count16 !== 16'(mCount) || countW !== 2'(mCount))
                $display("[TB] FAIL random%0d_count: got %0d/%0d expected %0d", c, count16, countW, mCount);
            else passCount++;
            applyStimulus();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 3'd0;
        zero      = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        test_reset();
        test_lda();
        test_sto_jmp();
        test_skz();
        test_hlt();
        test_step_mode();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
- Instruction sequencer for the VeriRISC datapath; sits directly upstream of the program counter and drives its inc/load controls (inc_pc -> enab, ld_pc -> load).
- Also drives the address mux select, memory read/write strobes, IR/AC load enables and the data bus enable.
- Steps every instruction through an 8-phase state machine, decoded from the opcode and the ALU zero flag.
- Adds a single-step debug mode, a sticky halt and a retired-instruction counter.

Parameters:
- OP_W, 3, opcode width. Encodings are fixed: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OP_W  current IR opcode field; only meaningful from phase 4 onward.
- zero  in  1  accumulator-zero flag.
- step_mode  in  1  1 = single-step debug operation.
- step_req  in  1  one-cycle pulse that releases one instruction in step mode.
- sel  out  1  address mux: 1 = PC, 0 = IR operand.
- rd  out  1  memory read.
- ld_ir  out  1  instruction register load.
- inc_pc  out  1  PC increment (counter enab).
- halt  out  1  processor halted.
- ld_pc  out  1  PC load (counter load).
- data_e  out  1  AC drives data bus.
- ld_ac  out  1  accumulator load.
- wr  out  1  memory write.
- phase  out  3  current phase, 0-7.
- waiting  out  1  parked in WAIT state (step mode).
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- States: P0 INST_ADDR, P1 INST_FETCH, P2 INST_LOAD, P3 IDLE, P4 OP_ADDR, P5 OP_FETCH, P6 ALU_OP, P7 STORE, WAIT, HALTED.
- Outputs are combinational from the registered state plus opcode/zero. No extra latency.
- Reset: rst high at an edge gives state=P0, instr_count=0, halt=0, waiting=0, phase=0. Resulting outputs: sel=1, all other strobes 0. Reset overrides every state, including HALTED and WAIT, and mid-instruction.
- Normal sequencing: P0->P1->...->P7, one phase per clock.
- After P7:
  - step_mode=0: go to P0.
  - step_mode=1: go to WAIT.
- WAIT:
  - outputs sel=1, waiting=1, phase=0, all other strobes 0.
  - step_req=1 or step_mode=0: go to P1. Fetch has already been addressed, so the instruction takes 8 cycles total.
  - otherwise hold.
- step_req outside WAIT is ignored. It is not queued.
- Step-mode entry after reset: P0 goes to WAIT when step_mode=1, and to P1 otherwise.
- Decode flags: ALUOP = ADD|AND|XOR|LDA; SKZ_T = (opcode==SKZ) & zero.
- Phase outputs (anything not listed is 0):
  - P0: sel.
  - P1: sel, rd.
  - P2: sel, rd, ld_ir.
  - P3: sel, rd, ld_ir.
  - P4: inc_pc. If opcode==HLT: halt=1.
  - P5: rd=ALUOP.
  - P6: rd=ALUOP, inc_pc=SKZ_T, ld_pc=JMP, data_e=STO.
  - P7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- HLT:
  - In P4 with opcode HLT, next state is HALTED.
  - HALTED outputs: halt=1, phase=4, all other strobes 0.
  - Exit only via rst. step_req and step_mode are ignored while halted.
- instr_count:
  - increments by 1 on the P7 exit edge, and on the P4->HALTED edge.
  - wraps modulo 2^CNT_W with no flag.
- P4 inc_pc with a same-instruction JMP ld_pc in P6/P7 is legal. The counter gives load priority.
- SKZ with zero=0 produces only the P4 increment.
- opcode/zero changes in phases 0-3 must not affect outputs except P4-P7 decoding. zero is sampled combinationally in P6 only.

Decomposition:
- Package sequence_pkg holds:
  - opcode localparams HLT..JMP;
  - state encoding enum {P0..P7, WAIT, HALTED}, 4 bits;
  - function is_aluop(opcode).
- Single module. The output decoder may be one always_comb case on state.
- No sub-module is required.

Test Plan:
- Reset then LDA (opcode=5), step_mode=0:
  - sel=1 in cycles 0-3; rd=1 in cycles 1-3 and 5-7; ld_ir in cycles 2-3; inc_pc in cycle 4; ld_ac in cycle 7.
  - instr_count=1 after cycle 7; phase returns to 0.
- STO (6) then JMP (7) back-to-back:
  - STO: data_e in P6-P7, wr in P7 only, rd=0 in P5-P7.
  - JMP: ld_pc in P6-P7, inc_pc in P4 only.
  - instr_count=2.
- SKZ (1):
  - zero=1: inc_pc pulses in P4 and P6.
  - zero=0: inc_pc pulses in P4 only.
  - Neither case asserts ld_ac, wr or ld_pc.
- HLT (0):
  - halt=1 from P4.
  - state holds HALTED with halt=1 and strobes 0 for 20 cycles despite step_req pulses; instr_count=1.
  - rst gives halt=0, phase=0.
- step_mode=1 with ADD (2):
  - parks in WAIT (waiting=1) after reset and after each P7.
  - no advance for 10 cycles.
  - a step_req pulse gives P1..P7 then WAIT; instr_count +1 per pulse.
  - a step_req during P3 is ignored.
- Counter wrap with CNT_W=2: 5 instructions give instr_count = 1,2,3,0,1.
- rst asserted in P6 of a JMP: ld_pc drops next cycle and state=P0.
